// File: rtl/gradient_window_ctrl.sv
// Raster-scan 3x3 cross window sequencer: buffers two rows and emits the
// p2/p4/p5/p6/p8 taps for every interior pixel through a valid/ready register.
module gradient_window_ctrl #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16,
  parameter int COL_W  = $clog2(WIDTH),
  parameter int ROW_W  = $clog2(HEIGHT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_pixel,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [7:0]       p2,
  output logic [7:0]       p4,
  output logic [7:0]       p5,
  output logic [7:0]       p6,
  output logic [7:0]       p8,
  output logic [ROW_W-1:0] out_row,
  output logic [COL_W-1:0] out_col,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_n;
  logic [ROW_W-1:0] ir;
  logic [COL_W-1:0] ic;
  logic [7:0]       lb1 [WIDTH];  // row ir-1 ahead of ic, row ir behind it
  logic [7:0]       lb2 [WIDTH];  // one row older than lb1
  logic [7:0]       top0, mid0, mid1, bot0;
  logic             accept, hs, load, last_px;

  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign hs       = out_valid && out_ready;
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);
  assign last_px  = (ir == ROW_W'(HEIGHT - 1)) && (ic == COL_W'(WIDTH - 1));
  assign load     = accept && (ir >= ROW_W'(2)) && (ic >= COL_W'(2));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (accept && last_px) state_n = DRAIN;
      DRAIN:   if (hs) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ir        <= '0;
      ic        <= '0;
      out_valid <= 1'b0;
      p2        <= '0;
      p4        <= '0;
      p5        <= '0;
      p6        <= '0;
      p8        <= '0;
      out_row   <= '0;
      out_col   <= '0;
      top0      <= '0;
      mid0      <= '0;
      mid1      <= '0;
      bot0      <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        ir <= '0;
        ic <= '0;
      end
      if (accept) begin
        if (ic == COL_W'(WIDTH - 1)) begin
          ic <= '0;
          ir <= ir + ROW_W'(1);
        end else begin
          ic <= ic + COL_W'(1);
        end
        // Column-(ic) values become the column-(ic-1) taps for the next pixel
        top0 <= lb2[ic];
        mid1 <= mid0;
        mid0 <= lb1[ic];
        bot0 <= in_pixel;
      end
      if (load) begin
        p2        <= top0;
        p4        <= mid1;
        p5        <= mid0;
        p6        <= lb1[ic];
        p8        <= bot0;
        out_row   <= ir - ROW_W'(1);
        out_col   <= ic - COL_W'(1);
        out_valid <= 1'b1;
      end else if (hs) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Line buffers carry no reset: every tap is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[ic] <= in_pixel;
      lb2[ic] <= lb1[ic];
    end
  end

endmodule

// File: tb/tb_gradient_window_ctrl.sv
// Scoreboard bench for gradient_window_ctrl: 4x4, 16x16 and 3x3 instances,
// one frame in flight at a time, taps predicted directly from the image array.
module tb_gradient_window_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [3], start [3], in_valid [3], out_ready [3];
  logic [7:0] in_pixel [3];
  logic       in_ready [3], out_valid [3], busy [3], done [3];
  logic [7:0] p2 [3], p4 [3], p5 [3], p6 [3], p8 [3];
  logic [1:0] row0, col0, row2, col2;
  logic [3:0] row1, col1;
  logic [7:0] orow [3], ocol [3];

  assign orow[0] = {6'b0, row0};
  assign ocol[0] = {6'b0, col0};
  assign orow[1] = {4'b0, row1};
  assign ocol[1] = {4'b0, col1};
  assign orow[2] = {6'b0, row2};
  assign ocol[2] = {6'b0, col2};

  gradient_window_ctrl #(.WIDTH(4), .HEIGHT(4)) u_dut4 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .in_valid(in_valid[0]),
    .in_pixel(in_pixel[0]), .in_ready(in_ready[0]), .out_ready(out_ready[0]),
    .out_valid(out_valid[0]), .p2(p2[0]), .p4(p4[0]), .p5(p5[0]), .p6(p6[0]),
    .p8(p8[0]), .out_row(row0), .out_col(col0), .busy(busy[0]), .done(done[0]));

  gradient_window_ctrl #(.WIDTH(16), .HEIGHT(16)) u_dut16 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .in_valid(in_valid[1]),
    .in_pixel(in_pixel[1]), .in_ready(in_ready[1]), .out_ready(out_ready[1]),
    .out_valid(out_valid[1]), .p2(p2[1]), .p4(p4[1]), .p5(p5[1]), .p6(p6[1]),
    .p8(p8[1]), .out_row(row1), .out_col(col1), .busy(busy[1]), .done(done[1]));

  gradient_window_ctrl #(.WIDTH(3), .HEIGHT(3)) u_dut3 (
    .clk(clk), .rst(rst[2]), .start(start[2]), .in_valid(in_valid[2]),
    .in_pixel(in_pixel[2]), .in_ready(in_ready[2]), .out_ready(out_ready[2]),
    .out_valid(out_valid[2]), .p2(p2[2]), .p4(p4[2]), .p5(p5[2]), .p6(p6[2]),
    .p8(p8[2]), .out_row(row2), .out_col(col2), .busy(busy[2]), .done(done[2]));

  typedef struct packed {
    logic [7:0] row, col, t2, t4, t5, t6, t8;
  } win_t;

  win_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   img [16][16];
  int   ready_mode [3];
  bit   active [3], act_pend [3], exp_done [3], held_v [3];
  win_t held [3];

  function automatic int wof(input int k);
    return (k == 0) ? 4 : (k == 1) ? 16 : 3;
  endfunction

  function automatic win_t cur(input int k);
    return '{orow[k], ocol[k], p2[k], p4[k], p5[k], p6[k], p8[k]};
  endfunction

  task automatic chk(input string name, input int k, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %h expected %h", name, k, got, exp);
    end
  endtask

  // Monitor: handshakes, hold under backpressure, busy window, done timing
  always @(negedge clk) begin
    win_t w;
    for (int k = 0; k < 3; k++) begin
      if (rst[k]) begin
        q.delete();
        active[k]   = 1'b0;
        act_pend[k] = 1'b0;
        exp_done[k] = 1'b0;
        held_v[k]   = 1'b0;
      end else begin
        if (done[k] || exp_done[k]) chk("done", k, 64'(done[k]), 64'(exp_done[k]));
        if (done[k]) active[k] = 1'b0;
        exp_done[k] = 1'b0;
        if (act_pend[k]) begin
          active[k]   = 1'b1;
          act_pend[k] = 1'b0;
        end
        chk("busy", k, 64'(busy[k]), 64'(active[k]));
        if (!active[k] && !done[k] && start[k]) act_pend[k] = 1'b1;
        if (held_v[k]) chk("hold", k, 64'(cur(k)), 64'(held[k]));
        if (out_valid[k] && !out_ready[k]) begin
          chk("in_ready_stall", k, 64'(in_ready[k]), 64'(0));
          held_v[k] = 1'b1;
          held[k]   = cur(k);
        end else begin
          held_v[k] = 1'b0;
        end
        if (out_valid[k] && out_ready[k]) begin
          if (q.size() == 0) begin
            chk("extra_output", k, 64'(cur(k)), 64'(0));
          end else begin
            w = q.pop_front();
            chk("taps", k, 64'(cur(k)), 64'(w));
            if (q.size() == 0) exp_done[k] = 1'b1;
          end
        end
      end
    end
  end

  // out_ready driver: 0 = always ready, 1 = random, 2 = 3-cycle stall on window (1,2)
  initial begin
    int stall_cnt [3];
    bit stalled [3];
    for (int k = 0; k < 3; k++) begin
      out_ready[k] = 1'b1;
      stall_cnt[k] = 0;
      stalled[k]   = 1'b0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        case (ready_mode[k])
          1: out_ready[k] = 1'($urandom_range(1));
          2: begin
            if (stall_cnt[k] > 0) begin
              out_ready[k] = 1'b0;
              stall_cnt[k]--;
            end else if (!stalled[k] && out_valid[k] && orow[k] == 8'd1 && ocol[k] == 8'd2) begin
              out_ready[k] = 1'b0;
              stall_cnt[k] = 2;
              stalled[k]   = 1'b1;
            end else begin
              out_ready[k] = 1'b1;
            end
          end
          default: begin
            out_ready[k] = 1'b1;
            stalled[k]   = 1'b0;
          end
        endcase
      end
    end
  end

  task automatic check_idle(input int k);
    chk("idle_outputs", k, 64'({out_valid[k], in_ready[k], busy[k], done[k], cur(k)}), 64'(0));
  endtask

  task automatic run_frame(input int k, input int gap, input bit noise, input int abort_at, input bit ramp);
    int w, stalls, guard;
    bit acc;
    w = wof(k);
    stalls = 0;
    for (int r = 0; r < w; r++)
      for (int c = 0; c < w; c++)
        img[r][c] = ramp ? ((w * r + c) & 255) : int'($urandom_range(255));
    for (int r = 1; r < w - 1; r++)
      for (int c = 1; c < w - 1; c++)
        q.push_back('{8'(r), 8'(c), 8'(img[r-1][c]), 8'(img[r][c-1]), 8'(img[r][c]),
                      8'(img[r][c+1]), 8'(img[r+1][c])});
    @(posedge clk); #1 start[k] = 1'b1;
    @(posedge clk); #1 start[k] = 1'b0;
    chk("in_ready_after_start", k, 64'(in_ready[k]), 64'(1));
    for (int idx = 0; idx < w * w; idx++) begin
      if (idx == abort_at) begin
        in_valid[k] = 1'b0;
        rst[k] = 1'b1;
        @(posedge clk); #1 rst[k] = 1'b0;
        check_idle(k);
        repeat (6) @(posedge clk);
        #1 check_idle(k);
        return;
      end
      while (int'($urandom_range(99)) < gap) begin
        in_valid[k] = 1'b0;
        @(posedge clk); #1;
      end
      in_valid[k] = 1'b1;
      in_pixel[k] = 8'(img[idx / w][idx % w]);
      if (noise && idx == w + 1) start[k] = 1'b1;
      guard = 0;
      do begin
        @(negedge clk);
        acc = in_ready[k];
        @(posedge clk); #1;
        start[k] = 1'b0;
        guard++;
      end while (!acc && guard < 200);
      if (!acc) begin
        chk("accept_timeout", k, 64'(0), 64'(1));
        in_valid[k] = 1'b0;
        return;
      end
      stalls += guard - 1;
    end
    in_valid[k] = 1'b0;
    if (noise) begin
      start[k] = 1'b1;
      @(posedge clk); #1 start[k] = 1'b0;
    end
    if (gap == 0 && ready_mode[k] == 0) chk("throughput_stalls", k, 64'(stalls), 64'(0));
    guard = 0;
    while ((active[k] || q.size() != 0) && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    #1;
    if (guard >= 5000) chk("frame_timeout", k, 64'(q.size()), 64'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; start[k] = 1'b0; in_valid[k] = 1'b0; in_pixel[k] = 8'd0;
      ready_mode[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check_idle(k);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run_frame(0, 0, 1'b0, -1, 1'b1);       // ramp 4x4, full throughput
    ready_mode[0] = 2;
    run_frame(0, 0, 1'b0, -1, 1'b1);       // same frame with 3-cycle stall at (1,2)
    ready_mode[0] = 0;
    ready_mode[1] = 1;
    run_frame(1, 50, 1'b0, -1, 1'b0);      // 16x16 random gaps and backpressure
    ready_mode[1] = 0;
    run_frame(0, 0, 1'b1, -1, 1'b0);       // start pulsed in RUN and DRAIN
    run_frame(0, 30, 1'b0, -1, 1'b0);      // second frame, no stale data
    run_frame(0, 0, 1'b0, 11, 1'b0);       // reset mid-row 2 with output pending
    run_frame(0, 0, 1'b0, -1, 1'b1);       // full frame after abort
    run_frame(2, 0, 1'b0, -1, 1'b0);       // minimum 3x3 frame
    ready_mode[2] = 1;
    run_frame(2, 40, 1'b0, -1, 1'b0);
    run_frame(1, 0, 1'b0, -1, 1'b0);       // 16x16 full throughput

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
